// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
//
// Per-output-port switch allocator for a 5-port router. Every input presents
// the one output its current flit needs (one-hot) plus a tail flag. Each output
// arbitrates round-robin among its requesters, gated by downstream readiness,
// and drives a registered one-hot crossbar select one cycle after the grant.
//
// Optional feature (compile-time macro):
//   SA_PKT_LOCK_EN  defined   : wormhole locking. An output stays bound to the
//                               winning input from head flit to tail flit.
//                   undefined : flit-level round-robin. Tails are ignored and
//                               every grant advances the pointer.
//
// Ports:
//   clk                          router clock, rising edge
//   rstn                         asynchronous active-low reset
//   req_from_P0..P4   [N-1:0]    one-hot requested output (0 = no request;
//                                multi-bit is masked to its lowest set bit)
//   tail_from_P0..P4             current flit is a tail
//   out_ready         [N-1:0]    bit j: output j can accept a flit this cycle
//   grant_to_P0..P4              combinational grant to input i
//   sel_for_OP0..OP4  [N-1:0]    registered one-hot crossbar select per output
//
// N is fixed at 5: the round-robin pointer is a 3-bit modulo-5 counter.
// -----------------------------------------------------------------------------
module switch_allocator #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req_from_P0,
  input  logic [N-1:0] req_from_P1,
  input  logic [N-1:0] req_from_P2,
  input  logic [N-1:0] req_from_P3,
  input  logic [N-1:0] req_from_P4,
  input  logic         tail_from_P0,
  input  logic         tail_from_P1,
  input  logic         tail_from_P2,
  input  logic         tail_from_P3,
  input  logic         tail_from_P4,
  input  logic [N-1:0] out_ready,
  output logic         grant_to_P0,
  output logic         grant_to_P1,
  output logic         grant_to_P2,
  output logic         grant_to_P3,
  output logic         grant_to_P4,
  output logic [N-1:0] sel_for_OP0,
  output logic [N-1:0] sel_for_OP1,
  output logic [N-1:0] sel_for_OP2,
  output logic [N-1:0] sel_for_OP3,
  output logic [N-1:0] sel_for_OP4
);

  localparam int PW = 3;
  typedef logic [PW-1:0] idx_t;

  // Next round-robin position, wrapping N-1 back to 0.
  function automatic idx_t inc_mod(input idx_t v);
    return (v == idx_t'(N - 1)) ? '0 : v + idx_t'(1);
  endfunction

  // First set bit of cand searching ptr, ptr+1, ... mod N.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] cand, input idx_t ptr);
    logic found;
    idx_t p;
    idx_t win;
    found = 1'b0;
    win   = '0;
    p     = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && cand[p]) begin
        found = 1'b1;
        win   = p;
      end
      p = inc_mod(p);
    end
    return {found, win};
  endfunction

  // ---------------------------------------------------------------------------
  // Input gathering
  // ---------------------------------------------------------------------------
  logic [N-1:0] req_raw [N];
  logic [N-1:0] req_m   [N];
  logic         tail    [N];
  logic [N-1:0] cand    [N];   // cand[j][i]: input i requests output j

  assign req_raw[0] = req_from_P0;
  assign req_raw[1] = req_from_P1;
  assign req_raw[2] = req_from_P2;
  assign req_raw[3] = req_from_P3;
  assign req_raw[4] = req_from_P4;

  assign tail[0] = tail_from_P0;
  assign tail[1] = tail_from_P1;
  assign tail[2] = tail_from_P2;
  assign tail[3] = tail_from_P3;
  assign tail[4] = tail_from_P4;

  // x & -x isolates the lowest set bit, so an illegal multi-bit request
  // degrades to a single legal one and an input never targets two outputs.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_m[i] = req_raw[i] & (~req_raw[i] + N'(1));
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        cand[j][i] = req_m[i][j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-output state
  // ---------------------------------------------------------------------------
  idx_t         ptr_q   [N];
  idx_t         ptr_d   [N];
  logic [N-1:0] sel_q   [N];
  logic [N-1:0] sel_d   [N];
  logic         win_vld [N];
  idx_t         win_idx [N];
  logic [N-1:0] gnt;
  logic [PW:0]  pick;

`ifdef SA_PKT_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} state_e;
  state_e state_q [N];
  state_e state_d [N];
  idx_t   owner_q [N];
  idx_t   owner_d [N];
`else
  // Tails carry no meaning without packet locking.
  logic unused_tail;
  assign unused_tail = ^{tail[0], tail[1], tail[2], tail[3], tail[4]};
`endif

  // NOTE: every variable written here gets a default before any condition;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    pick = '0;
    for (int j = 0; j < N; j++) begin
      ptr_d[j]   = ptr_q[j];
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
`ifdef SA_PKT_LOCK_EN
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
`endif
      pick = rr_pick(cand[j], ptr_q[j]);

      // Grants are forced low while reset is held, and no grant is issued for
      // an output without downstream credit.
      if (rstn && out_ready[j]) begin
`ifdef SA_PKT_LOCK_EN
        if (state_q[j] == S_LOCKED) begin
          // Only the owner may advance; a bubble simply holds the lock.
          if (cand[j][owner_q[j]]) begin
            win_vld[j] = 1'b1;
            win_idx[j] = owner_q[j];
            if (tail[owner_q[j]]) begin
              state_d[j] = S_IDLE;
              ptr_d[j]   = inc_mod(owner_q[j]);
            end
          end
        end else if (pick[PW]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = pick[PW-1:0];
          if (tail[pick[PW-1:0]]) begin
            ptr_d[j] = inc_mod(pick[PW-1:0]);
          end else begin
            // Head of a multi-flit packet: the pointer stays put until the
            // tail releases the output.
            state_d[j] = S_LOCKED;
            owner_d[j] = pick[PW-1:0];
          end
        end
`else
        if (pick[PW]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = pick[PW-1:0];
          ptr_d[j]   = inc_mod(pick[PW-1:0]);
        end
`endif
      end
    end
  end

  // Each input targets at most one output, so at most one term per input is set.
  always_comb begin
    gnt = '0;
    for (int j = 0; j < N; j++) begin
      sel_d[j] = win_vld[j] ? (N'(1) << win_idx[j]) : '0;
      if (win_vld[j]) begin
        gnt[win_idx[j]] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: these per-output arrays are a handful of flops, not RAM, so they all
  // take the asynchronous reset; a mid-packet reset must drop every lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N; j++) begin
        ptr_q[j] <= '0;
        sel_q[j] <= '0;
`ifdef SA_PKT_LOCK_EN
        state_q[j] <= S_IDLE;
        owner_q[j] <= '0;
`endif
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        ptr_q[j] <= ptr_d[j];
        sel_q[j] <= sel_d[j];
`ifdef SA_PKT_LOCK_EN
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant_to_P0 = gnt[0];
  assign grant_to_P1 = gnt[1];
  assign grant_to_P2 = gnt[2];
  assign grant_to_P3 = gnt[3];
  assign grant_to_P4 = gnt[4];

  assign sel_for_OP0 = sel_q[0];
  assign sel_for_OP1 = sel_q[1];
  assign sel_for_OP2 = sel_q[2];
  assign sel_for_OP3 = sel_q[3];
  assign sel_for_OP4 = sel_q[4];

endmodule

// File: tb/tb_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator
//
// Self-checking bench for switch_allocator. A behavioural model (distance-based
// round-robin choice, per-output lock flags) predicts grants and selects every
// cycle; directed sequences with literal expectations pin the model, then a
// randomized packet-traffic phase runs against it. Follows SA_PKT_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_switch_allocator;

  localparam int N = 5;
`ifdef SA_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [N-1:0] BP_G [7] = '{5'b00010, 5'b00010, 5'b00000, 5'b00000,
                                        5'b00000, 5'b00010, 5'b00100};
  localparam logic [N-1:0] BP_S [7] = '{5'b00000, 5'b00010, 5'b00010, 5'b00000,
                                        5'b00000, 5'b00000, 5'b00010};

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] req  [N];
  logic         tail [N];
  logic [N-1:0] out_ready;
  wire  [N-1:0] gvec;
  wire  [N-1:0] sel  [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_allocator #(.N(N)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_from_P0  (req[0]),
    .req_from_P1  (req[1]),
    .req_from_P2  (req[2]),
    .req_from_P3  (req[3]),
    .req_from_P4  (req[4]),
    .tail_from_P0 (tail[0]),
    .tail_from_P1 (tail[1]),
    .tail_from_P2 (tail[2]),
    .tail_from_P3 (tail[3]),
    .tail_from_P4 (tail[4]),
    .out_ready    (out_ready),
    .grant_to_P0  (gvec[0]),
    .grant_to_P1  (gvec[1]),
    .grant_to_P2  (gvec[2]),
    .grant_to_P3  (gvec[3]),
    .grant_to_P4  (gvec[4]),
    .sel_for_OP0  (sel[0]),
    .sel_for_OP1  (sel[1]),
    .sel_for_OP2  (sel[2]),
    .sel_for_OP3  (sel[3]),
    .sel_for_OP4  (sel[4])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int           m_ptr   [N];
  bit           m_lock  [N];
  int           m_owner [N];
  bit [N-1:0]   m_sel   [N];
  bit           m_val   [N];
  int           m_win   [N];
  bit [N-1:0]   m_gnt;

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_ptr[j]   = 0;
      m_lock[j]  = 1'b0;
      m_owner[j] = 0;
      m_sel[j]   = '0;
      m_val[j]   = 1'b0;
      m_win[j]   = 0;
    end
    m_gnt = '0;
  endfunction

  // Winner = candidate at the smallest forward distance from the pointer.
  function automatic void model_eval();
    int dest [N];
    int best;
    int bestd;
    int d;
    for (int i = 0; i < N; i++) begin
      dest[i] = -1;
      for (int b = N - 1; b >= 0; b--) begin
        if (req[i][b] === 1'b1) dest[i] = b;
      end
    end
    m_gnt = '0;
    for (int j = 0; j < N; j++) begin
      m_val[j] = 1'b0;
      m_win[j] = 0;
      if (rstn === 1'b1 && out_ready[j] === 1'b1) begin
        if (LOCK_EN && m_lock[j]) begin
          if (dest[m_owner[j]] == j) begin
            m_val[j] = 1'b1;
            m_win[j] = m_owner[j];
          end
        end else begin
          best  = -1;
          bestd = N;
          for (int i = 0; i < N; i++) begin
            if (dest[i] == j) begin
              d = (i - m_ptr[j] + N) % N;
              if (d < bestd) begin
                bestd = d;
                best  = i;
              end
            end
          end
          if (best >= 0) begin
            m_val[j] = 1'b1;
            m_win[j] = best;
          end
        end
        if (m_val[j]) m_gnt[m_win[j]] = 1'b1;
      end
    end
  endfunction

  function automatic void model_update();
    for (int j = 0; j < N; j++) begin
      m_sel[j] = m_val[j] ? (5'b00001 << m_win[j]) : 5'b00000;
      if (m_val[j]) begin
        if (!LOCK_EN) begin
          m_ptr[j] = (m_win[j] + 1) % N;
        end else if (m_lock[j]) begin
          if (tail[m_win[j]]) begin
            m_lock[j] = 1'b0;
            m_ptr[j]  = (m_win[j] + 1) % N;
          end
        end else if (tail[m_win[j]]) begin
          m_ptr[j] = (m_win[j] + 1) % N;
        end else begin
          m_lock[j]  = 1'b1;
          m_owner[j] = m_win[j];
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else       model_update();
  end

  // Compare on the falling edge: inputs are stable, outputs have settled.
  always @(negedge clk) begin
    model_eval();
    check("grant", {27'd0, gvec}, {27'd0, m_gnt});
    check("sel", {7'd0, sel[4], sel[3], sel[2], sel[1], sel[0]},
                 {7'd0, m_sel[4], m_sel[3], m_sel[2], m_sel[1], m_sel[0]});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]  = '0;
      tail[i] = 1'b1;
    end
    out_ready = '1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  int rem [N];
  int dst [N];

  initial begin
    model_reset();
    idle_inputs();
    next_cycle();

    // Reset state: no selects, no grants.
    check("reset_sel0", {27'd0, sel[0]}, 32'd0);
    check("reset_gnt", {27'd0, gvec}, 32'd0);

    // Round robin on OP2 with single-flit packets from every input.
    do_reset();
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]  = 5'b00100;
        tail[i] = 1'b1;
      end
      @(negedge clk);
      check("rr_grant", {27'd0, gvec}, 32'd1 << c);
      if (c > 0) check("rr_sel", {27'd0, sel[2]}, 32'd1 << (c - 1));
      next_cycle();
    end
    @(negedge clk);
    check("rr_sel_last", {27'd0, sel[2]}, 32'h10);
    check("rr_wrap_grant", {27'd0, gvec}, 32'h01);
    next_cycle();
    idle_inputs();

    // Every input to a different output in the same cycle.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req[i]  = 5'b00001 << ((i + 1) % N);
      tail[i] = 1'b1;
    end
    @(negedge clk);
    check("par_grant", {27'd0, gvec}, 32'h1f);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      check("par_sel", {27'd0, sel[j]}, 32'd1 << ((j + 4) % N));
    end
    next_cycle();

`ifdef SA_PKT_LOCK_EN
    // P1 sends a 4-flit packet to OP0 while P3 waits.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req[1]  = (c < 4) ? 5'b00001 : 5'b00000;
      tail[1] = (c == 3);
      req[3]  = 5'b00001;
      tail[3] = 1'b1;
      @(negedge clk);
      check("lock_grant", {27'd0, gvec}, (c < 4) ? 32'h02 : 32'h08);
      next_cycle();
    end
    idle_inputs();

    // Backpressure on OP4 while locked to P1; P2 must stay blocked.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req[1]    = (c < 6) ? 5'b10000 : 5'b00000;
      tail[1]   = (c == 5);
      req[2]    = 5'b10000;
      tail[2]   = 1'b1;
      out_ready = (c >= 2 && c <= 4) ? 5'b01111 : 5'b11111;
      @(negedge clk);
      check("bp_grant", {27'd0, gvec}, {27'd0, BP_G[c]});
      check("bp_sel", {27'd0, sel[4]}, {27'd0, BP_S[c]});
      next_cycle();
    end
    idle_inputs();

    // Reset while OP2 is locked to P3.
    do_reset();
    req[3]  = 5'b00100;
    tail[3] = 1'b0;
    @(negedge clk);
    check("rmp_head", {27'd0, gvec}, 32'h08);
    next_cycle();
    req[0]  = 5'b00100;
    tail[0] = 1'b1;
    @(negedge clk);
    check("rmp_locked", {27'd0, gvec}, 32'h08);
    next_cycle();
    check("rmp_sel_before", {27'd0, sel[2]}, 32'h08);
    rstn = 1'b0;
    #1;
    check("rmp_sel_cleared", {27'd0, sel[2]}, 32'h00);
    check("rmp_grant_rst", {27'd0, gvec}, 32'h00);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check("rmp_after", {27'd0, gvec}, 32'h01);
    next_cycle();
    idle_inputs();
`else
    // Without locking, multi-flit streams interleave flit by flit.
    do_reset();
    req[0]  = 5'b00010;
    req[1]  = 5'b00010;
    tail[0] = 1'b0;
    tail[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flit_rr", {27'd0, gvec}, (c % 2 == 0) ? 32'h01 : 32'h02);
      next_cycle();
    end
    idle_inputs();
`endif

    // Randomized packet traffic with bubbles, backpressure, illegal multi-bit
    // requests and occasional mid-run resets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      dst[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i] && rem[i] > 0) rem[i]--;
      end
      if (rstn && $urandom_range(0, 299) == 0) begin
        rstn = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
      end else begin
        rstn = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 9) < 6) begin
          dst[i] = $urandom_range(0, N - 1);
          rem[i] = $urandom_range(1, 4);
        end
        if (rem[i] > 0 && $urandom_range(0, 9) != 0) begin
          req[i]  = 5'b00001 << dst[i];
          if ($urandom_range(0, 19) == 0) begin
            req[i] = req[i] | 5'($urandom() & ~((32'd2 << dst[i]) - 32'd1));
          end
          tail[i] = (rem[i] == 1);
        end else begin
          req[i]  = '0;
          tail[i] = 1'($urandom_range(0, 1));
        end
      end
      for (int j = 0; j < N; j++) begin
        out_ready[j] = ($urandom_range(0, 4) != 0);
      end
      next_cycle();
    end

    idle_inputs();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
